// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and FSM state type for the byte-serial adder
//
// Purpose : slice width and controller state encoding used by byte_serial_adder.
// Ports   : none (package).
package adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prefix_add8.sv
// rtl/prefix_add8.sv - combinational 8-bit parallel-prefix (Kogge-Stone) adder slice
//
// Purpose : one 8-bit add with carry-in, time-shared by the serial adder.
// Ports   : cin      - carry into bit 0
//           a, b     - 8-bit addends
//           s        - 8-bit sum
//           cout     - carry out of bit 7
module prefix_add8 (
  input  logic       cin,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] gn;
  logic [7:0] pn;
  logic [8:0] c;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    // Three doubling levels turn per-bit (g,p) into group (G,P) spanning bits [i:0].
    for (int lvl = 0; lvl < 3; lvl++) begin
      gn = g;
      pn = p;
      for (int i = (1 << lvl); i < 8; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
        pn[i] = p[i] & p[i - (1 << lvl)];
      end
      g = gn;
      p = pn;
    end
    // The carry-in enters only at the end: carry into bit i+1 = G[i:0] | P[i:0]&cin.
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i + 1] = g[i] | (p[i] & cin);
    end
    s    = (a ^ b) ^ c[7:0];
    cout = c[8];
  end

endmodule

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - W-bit adder computed one byte per cycle through a shared slice
//
// Purpose : captures a, b, cin, then sums one byte per RUN cycle (LSB first) and
//           presents {cout, s} in DONE until the consumer takes it.
// Ports   : clk, reset         - clock, synchronous active-high reset
//           in_valid, in_ready - operand handshake (ready only in IDLE)
//           cin, a, b          - carry-in and W-bit addends, W = 8*N_BYTES
//           out_valid, out_ready - result handshake (valid only in DONE)
//           s, cout            - W-bit sum and final carry-out
module byte_serial_adder
  import adder_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      cin,
  input  logic [BYTE_W*N_BYTES-1:0] a,
  input  logic [BYTE_W*N_BYTES-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W*N_BYTES-1:0] s,
  output logic                      cout
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_t                            state;
  logic [IDX_W-1:0]                  idx;
  logic [N_BYTES-1:0][BYTE_W-1:0]    a_q;
  logic [N_BYTES-1:0][BYTE_W-1:0]    b_q;
  logic [N_BYTES-1:0][BYTE_W-1:0]    s_q;
  logic                              carry;
  logic                              cout_q;

  logic [BYTE_W-1:0]                 slice_a;
  logic [BYTE_W-1:0]                 slice_b;
  logic [BYTE_W-1:0]                 slice_s;
  logic                              slice_cout;

  assign slice_a = a_q[idx];
  assign slice_b = b_q[idx];

  prefix_add8 u_add8 (
    .cin  (carry),
    .a    (slice_a),
    .b    (slice_b),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // The carry register is the only path between slices.
          s_q[idx] <= slice_s;
          carry    <= slice_cout;
          if (idx == LAST_IDX) begin
            cout_q <= slice_cout;
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = s_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - scoreboard bench for byte_serial_adder
module tb_byte_serial_adder;

  localparam int NB  = 4;
  localparam int W   = 8 * NB;
  localparam int LAT = NB;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;

  byte_serial_adder #(.N_BYTES(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
  );

  typedef struct {
    logic [W:0] exp;
    int         acc;
  } item_t;

  item_t exp_q[$];
  int    hs_cyc[$];
  int    cyc;
  int    compared;
  int    mismatched;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops on every accepted result and checks value and latency.
  initial begin
    int  rise_cyc;
    bit  prev_ov;
    item_t it;
    rise_cyc = 0;
    prev_ov  = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", {31'd0, cout, s}, 64'd0 - 64'd1);
        end else begin
          it = exp_q.pop_front();
          chk("sum", {31'd0, cout, s}, {31'd0, it.exp});
          chk("latency", 64'(rise_cyc - it.acc), 64'(LAT));
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  // Drives one operand set (called at posedge+1) and records its expectation on acceptance.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input logic [W:0] expv, input bit track);
    int n;
    item_t it;
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (track) begin
      it.exp = expv;
      it.acc = cyc;
      exp_q.push_back(it);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] snap_s;
    logic         snap_c;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           n;

    cyc = 0;
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    cin = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);

    // Directed vectors with hand-computed {cout, s}.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000}, 1'b1);
    drain();
    send(32'h1234_5678, 32'h1111_1111, 1'b1, {1'b0, 32'h2345_678A}, 1'b1);
    drain();
    send(32'h0000_0000, 32'h0000_0000, 1'b0, {1'b0, 32'h0000_0000}, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF}, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0000_0000}, 1'b1);
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_0100}, 1'b1);
    send(32'h00FF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 32'h0100_0000}, 1'b1);
    drain();

    // Result held under back-pressure while inputs toggle.
    out_ready = 1'b0;
    send(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, {1'b1, 32'h0000_0000}, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_out_valid_seen", 64'(out_valid), 64'd1);
    snap_s = s;
    snap_c = cout;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      chk("hold_s", 64'(s), 64'(snap_s));
      chk("hold_cout", 64'(cout), 64'(snap_c));
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Reset during the second RUN cycle aborts the operation.
    send(32'hFF00_FF00, 32'h0100_FF00, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_s", 64'(s), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(out_valid), 64'd0);

    // Back-to-back: three results spaced N_BYTES+2 cycles apart.
    hs_cyc.delete();
    send(32'h1111_1111, 32'h2222_2222, 1'b0, {1'b0, 32'h3333_3333}, 1'b1);
    send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, {1'b0, 32'hDFAE_BFF0}, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 32'h8000_0000}, 1'b1);
    drain();
    chk("b2b_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'(NB + 2));
      chk("b2b_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'(NB + 2));
    end

    // Random operands against a W+1-bit reference sum.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}, 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
